// File: rtl/frame_scan_ctl.sv
// frame_scan_ctl: owns the ping-pong bank select and schedules cube RAM readout into the serialiser.
// Optional AUTO_REFRESH_EN: rescan the front bank (no swap) after REFRESH_CYCLES idle cycles.
module frame_scan_ctl #(
  parameter int unsigned LAYERS         = 8,
  parameter int unsigned PIX_PER_LAYER  = 64,
  parameter int unsigned REFRESH_CYCLES = 2400000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        frame_rdy_in,
  output logic        bank_wr_out,
  output logic        bank_rd_out,
  output logic        rd_en_out,
  output logic [2:0]  rd_layer_out,
  output logic [5:0]  rd_addr_out,
  input  logic [23:0] rd_data_in,
  output logic        pix_valid_out,
  output logic [23:0] pix_data_out,
  input  logic        pix_ready_in,
  output logic        latch_req_out,
  input  logic        latch_done_in,
  output logic        busy_out,
  output logic        frame_drop_out
);

  localparam logic [2:0] LAYER_LAST = 3'(LAYERS - 1);
  localparam logic [5:0] ADDR_LAST  = 6'(PIX_PER_LAYER - 1);

  if (LAYERS < 1 || LAYERS > 8 || PIX_PER_LAYER < 1 || PIX_PER_LAYER > 64 ||
      REFRESH_CYCLES < 1 || REFRESH_CYCLES > 4194304) begin : g_bad_param
    $error("frame_scan_ctl: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_LATCH} state_t;

  state_t      state, state_nx;
  logic        bank_rd, bank_rd_nx;
  logic        pending, pending_nx;
  logic        drop_q, drop_nx;
  logic [2:0]  layer, layer_nx;
  logic [5:0]  addr, addr_nx;
  logic [23:0] pix, pix_nx;

`ifdef AUTO_REFRESH_EN
  localparam logic [21:0] REFRESH_LAST = 22'(REFRESH_CYCLES - 1);
  logic [21:0] idle_cnt, idle_cnt_nx;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) idle_cnt <= '0;
    else           idle_cnt <= idle_cnt_nx;
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= S_IDLE;
      bank_rd <= 1'b0;
      pending <= 1'b0;
      drop_q  <= 1'b0;
      layer   <= '0;
      addr    <= '0;
      pix     <= '0;
    end else begin
      state   <= state_nx;
      bank_rd <= bank_rd_nx;
      pending <= pending_nx;
      drop_q  <= drop_nx;
      layer   <= layer_nx;
      addr    <= addr_nx;
      pix     <= pix_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bank_rd_nx = bank_rd;
    pending_nx = pending;
    drop_nx    = 1'b0;
    layer_nx   = layer;
    addr_nx    = addr;
    pix_nx     = pix;
`ifdef AUTO_REFRESH_EN
    idle_cnt_nx = '0;
`endif
    case (state)
      S_IDLE: begin
        // A pending frame and a fresh pulse in the same cycle merge into one swap.
        if (pending || frame_rdy_in) begin
          bank_rd_nx = ~bank_rd;
          pending_nx = 1'b0;
          layer_nx   = '0;
          addr_nx    = '0;
          state_nx   = S_READ;
        end
`ifdef AUTO_REFRESH_EN
        else if (idle_cnt == REFRESH_LAST) begin
          layer_nx = '0;
          addr_nx  = '0;
          state_nx = S_READ;
        end else begin
          idle_cnt_nx = idle_cnt + 22'd1;
        end
`endif
      end
      S_READ: state_nx = S_WAIT;
      S_WAIT: begin
        pix_nx   = rd_data_in;
        state_nx = S_SEND;
      end
      S_SEND: begin
        if (pix_ready_in) begin
          state_nx = S_READ;
          if (addr == ADDR_LAST) begin
            addr_nx = '0;
            if (layer == LAYER_LAST) begin
              layer_nx = '0;
              state_nx = S_LATCH;
            end else begin
              layer_nx = layer + 3'd1;
            end
          end else begin
            addr_nx = addr + 6'd1;
          end
        end
      end
      S_LATCH: if (latch_done_in) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (state != S_IDLE && frame_rdy_in) begin
      pending_nx = 1'b1;
      drop_nx    = pending;
    end
  end

  assign bank_rd_out    = bank_rd;
  assign bank_wr_out    = ~bank_rd;
  assign rd_en_out      = (state == S_READ);
  assign pix_valid_out  = (state == S_SEND);
  assign latch_req_out  = (state == S_LATCH);
  assign busy_out       = (state != S_IDLE);
  assign frame_drop_out = drop_q;
  assign rd_layer_out   = layer;
  assign rd_addr_out    = addr;
  assign pix_data_out   = pix;

endmodule

// File: tb/tb_frame_scan_ctl.sv
// Bench for frame_scan_ctl: table-driven first scan, hand-written corner sequences and a
// randomized phase checked by a frame-level scoreboard. Honours AUTO_REFRESH_EN when defined.
module tb_frame_scan_ctl;
  localparam int L = 2;
  localparam int P = 4;
  localparam int N = L * P;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        frame_rdy_in = 1'b0;
  logic        bank_wr_out, bank_rd_out, rd_en_out;
  logic [2:0]  rd_layer_out;
  logic [5:0]  rd_addr_out;
  logic [23:0] rd_data_in = '0;
  logic        pix_valid_out;
  logic [23:0] pix_data_out;
  logic        pix_ready_in = 1'b0;
  logic        latch_req_out;
  logic        latch_done_in = 1'b0;
  logic        busy_out, frame_drop_out;

  frame_scan_ctl #(.LAYERS(L), .PIX_PER_LAYER(P), .REFRESH_CYCLES(100)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_rdy_in(frame_rdy_in),
    .bank_wr_out(bank_wr_out), .bank_rd_out(bank_rd_out), .rd_en_out(rd_en_out),
    .rd_layer_out(rd_layer_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .pix_valid_out(pix_valid_out), .pix_data_out(pix_data_out), .pix_ready_in(pix_ready_in),
    .latch_req_out(latch_req_out), .latch_done_in(latch_done_in), .busy_out(busy_out),
    .frame_drop_out(frame_drop_out));

  always #5 clk_in = ~clk_in;

  // Two-bank RAM, one cycle read latency; junk on the bus when not reading.
  logic [23:0] mem [0:1][0:7][0:63];
  always @(posedge clk_in)
    rd_data_in <= rd_en_out ? mem[bank_rd_out][rd_layer_out][rd_addr_out] : 24'($urandom);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Event counters and frame-level scoreboard, sampled on the falling edge.
  int rd_en_cnt = 0, drop_cnt = 0, tog_cnt = 0, scan_cnt = 0, acc_cnt = 0, cyc = 0;
  int w_idx = 0, last_acc = 0;
  bit sb_en = 0;
  logic m_bank = 1'b0, m_busy = 1'b0, m_latch = 1'b0, m_stall = 1'b0, sc_bank = 1'b0;
  logic [23:0] m_data = '0;

  always @(negedge clk_in) begin
    cyc++;
    if (rd_en_out) rd_en_cnt++;
    if (frame_drop_out) drop_cnt++;
    if (bank_rd_out !== m_bank) tog_cnt++;
    if (busy_out && !m_busy) begin
      scan_cnt++;
      if (sb_en) begin
`ifndef AUTO_REFRESH_EN
        check("sb swap at scan start", bank_rd_out, !m_bank);
`endif
        sc_bank = bank_rd_out;
        w_idx = 0;
      end
    end
    if (sb_en) begin
      check("sb bank_wr", bank_wr_out, !bank_rd_out);
      if (rd_en_out) begin
        check("sb rd index", {rd_layer_out, rd_addr_out}, {3'(w_idx / P), 6'(w_idx % P)});
        check("sb rd_en vs valid", pix_valid_out, 0);
      end
      if (m_stall) check("sb stall hold", {pix_valid_out, pix_data_out}, {1'b1, m_data});
      if (latch_req_out && !m_latch) check("sb words before latch", w_idx, N);
    end
    if (pix_valid_out && pix_ready_in) begin
      acc_cnt++;
      if (sb_en) begin
        check("sb pixel data", pix_data_out, mem[sc_bank][(w_idx / P) % 8][w_idx % P]);
        check("sb bank stable", bank_rd_out, sc_bank);
        if (w_idx > 0) check("sb pixel gap>=3", (cyc - last_acc) >= 3, 1);
        last_acc = cyc;
        w_idx++;
      end
    end
    m_stall = pix_valid_out && !pix_ready_in;
    m_data  = pix_data_out;
    m_bank  = bank_rd_out;
    m_busy  = busy_out;
    m_latch = latch_req_out;
  end

  task automatic finish_scan(input string name);
    int n = 0;
    while (!latch_req_out && n < 300) begin
      tick(1);
      n++;
    end
    check({name, " latch_req"}, latch_req_out, 1);
    latch_done_in = 1'b1;
    tick(1);
    latch_done_in = 1'b0;
    check({name, " idle after latch"}, {busy_out, latch_req_out}, 2'b00);
  endtask

  task automatic reset_outputs(input string name);
    check({name, " ctl"}, {busy_out, rd_en_out, pix_valid_out, latch_req_out, frame_drop_out,
                           bank_rd_out, bank_wr_out}, 7'b0000001);
    check({name, " idx"}, {rd_layer_out, rd_addr_out}, 0);
    check({name, " data"}, pix_data_out, 0);
  endtask

  typedef struct {
    logic frdy, rdy, ldone;
    logic busy, rd_en, valid, latch, bank;
    logic [2:0] layer;
    logic [5:0] addr;
    logic chk_idx, chk_data;
    logic [23:0] data;
  } vec_t;
  vec_t vt [28];

  int a0, r0, t0, d0, s0, n, rdy_pulses, lwait, idle_run;
  bit hold_ok, prev_ldone;
  logic [23:0] held;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 8; l++)
        for (int a = 0; a < 64; a++) mem[b][l][a] = 24'($urandom);

    for (int i = 0; i < 28; i++) vt[i] = '{default: '0};
    for (int k = 0; k < N; k++) begin
      for (int s = 0; s < 3; s++) begin
        vt[3*k+s].rdy = 1'b1;
        vt[3*k+s].busy = 1'b1;
        vt[3*k+s].bank = 1'b1;
        vt[3*k+s].layer = 3'(k / P);
        vt[3*k+s].addr = 6'(k % P);
        vt[3*k+s].chk_idx = 1'b1;
      end
      vt[3*k].frdy = (k == 0);
      vt[3*k].rd_en = 1'b1;
      vt[3*k+2].valid = 1'b1;
      vt[3*k+2].chk_data = 1'b1;
      vt[3*k+2].data = mem[1][k / P][k % P];
    end
    for (int i = 24; i < 28; i++) begin
      vt[i].rdy = 1'b1;
      vt[i].bank = 1'b1;
      vt[i].chk_idx = 1'b1;
      vt[i].busy = (i < 26);
      vt[i].latch = (i < 26);
    end
    vt[26].ldone = 1'b1;

    // Reset state
    tick(3);
    reset_outputs("reset");
    rst_n_in = 1'b1;
    tick(2);
    check("idle without frame", busy_out, 0);

    // Test 1: table-driven first scan, bank 0 -> 1, eight words, latch handshake
    for (int i = 0; i < 28; i++) begin
      frame_rdy_in = vt[i].frdy;
      pix_ready_in = vt[i].rdy;
      latch_done_in = vt[i].ldone;
      tick(1);
      check($sformatf("vec%0d ctl", i),
            {busy_out, rd_en_out, pix_valid_out, latch_req_out, bank_rd_out, bank_wr_out},
            {vt[i].busy, vt[i].rd_en, vt[i].valid, vt[i].latch, vt[i].bank, ~vt[i].bank});
      if (vt[i].chk_idx)
        check($sformatf("vec%0d idx", i), {rd_layer_out, rd_addr_out}, {vt[i].layer, vt[i].addr});
      if (vt[i].chk_data) check($sformatf("vec%0d data", i), pix_data_out, vt[i].data);
    end
    frame_rdy_in = 1'b0;
    latch_done_in = 1'b0;

    // Test 2: stall on word 3 for 10 cycles
    r0 = rd_en_cnt; a0 = acc_cnt;
    frame_rdy_in = 1'b1;
    tick(1);
    frame_rdy_in = 1'b0;
    check("t2 swap to bank0", bank_rd_out, 0);
    n = 0;
    while (!(acc_cnt - a0 == 2 && pix_valid_out) && n < 100) begin
      if (acc_cnt - a0 == 2) pix_ready_in = 1'b0;
      tick(1);
      n++;
    end
    held = pix_data_out;
    check("t2 word3 data", held, mem[0][0][2]);
    hold_ok = 1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (!(pix_valid_out === 1'b1 && pix_data_out === held)) hold_ok = 0;
    end
    check("t2 valid/data held", hold_ok, 1);
    check("t2 no extra rd_en", rd_en_cnt - r0, 3);
    pix_ready_in = 1'b1;
    finish_scan("t2");
    check("t2 total rd_en", rd_en_cnt - r0, N);
    check("t2 total words", acc_cnt - a0, N);

    // Test 3: two frames during a scan -> one drop, one deferred swap
    t0 = tog_cnt; d0 = drop_cnt;
    frame_rdy_in = 1'b1;
    tick(1);
    frame_rdy_in = 1'b0;
    tick(5);
    frame_rdy_in = 1'b1;
    tick(1);
    frame_rdy_in = 1'b0;
    tick(3);
    frame_rdy_in = 1'b1;
    tick(1);
    frame_rdy_in = 1'b0;
    finish_scan("t3 first");
    tick(1);
    check("t3 pending scan starts", {busy_out, rd_en_out, bank_rd_out}, 3'b110);
    finish_scan("t3 second");
    hold_ok = 1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (busy_out !== 1'b0) hold_ok = 0;
    end
    check("t3 no third scan", hold_ok, 1);
    check("t3 drops", drop_cnt - d0, 1);
    check("t3 swaps", tog_cnt - t0, 2);

    // Test 4: frame_rdy with latch_done, then again in the IDLE cycle: one swap, no drop
    t0 = tog_cnt; d0 = drop_cnt;
    frame_rdy_in = 1'b1;
    tick(1);
    frame_rdy_in = 1'b0;
    n = 0;
    while (!latch_req_out && n < 300) begin
      tick(1);
      n++;
    end
    check("t4 latch_req", latch_req_out, 1);
    latch_done_in = 1'b1;
    frame_rdy_in = 1'b1;
    tick(1);
    latch_done_in = 1'b0;
    check("t4 idle one cycle", busy_out, 0);
    tick(1);
    frame_rdy_in = 1'b0;
    check("t4 rescan toggled", {busy_out, rd_en_out, bank_rd_out}, 3'b110);
    finish_scan("t4");
    tick(10);
    check("t4 idle after", busy_out, 0);
    check("t4 swaps", tog_cnt - t0, 2);
    check("t4 drops", drop_cnt - d0, 0);

    // Test 5: reset mid-SEND
    pix_ready_in = 1'b0;
    frame_rdy_in = 1'b1;
    tick(1);
    frame_rdy_in = 1'b0;
    n = 0;
    while (!pix_valid_out && n < 20) begin
      tick(1);
      n++;
    end
    check("t5 in SEND", {pix_valid_out, bank_rd_out}, 2'b11);
    @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 reset_outputs("t5 async reset");
    tick(1);
    rst_n_in = 1'b1;
    pix_ready_in = 1'b1;
    hold_ok = 1;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      if (busy_out !== 1'b0 || latch_req_out !== 1'b0) hold_ok = 0;
    end
    check("t5 no scan/latch after reset", hold_ok, 1);

    // Randomized phase against the frame-level scoreboard
    sb_en = 1;
    s0 = scan_cnt; d0 = drop_cnt; a0 = acc_cnt;
    rdy_pulses = 0; lwait = 0; prev_ldone = 0;
    for (int c = 0; c < 3000; c++) begin
      prev_ldone = latch_done_in;
      pix_ready_in = ($urandom_range(0, 9) < 7);
      if (latch_done_in) latch_done_in = 1'b0;
      else if (latch_req_out) begin
        if (lwait == 0) begin
          latch_done_in = 1'b1;
          lwait = $urandom_range(0, 4);
        end else lwait--;
      end
      if (!prev_ldone && $urandom_range(0, 24) == 0) begin
        for (int l = 0; l < L; l++)
          for (int a = 0; a < P; a++) mem[!bank_rd_out][l][a] = 24'($urandom);
        frame_rdy_in = 1'b1;
        rdy_pulses++;
      end else frame_rdy_in = 1'b0;
      tick(1);
    end
    frame_rdy_in = 1'b0;
    pix_ready_in = 1'b1;
    idle_run = 0;
    for (int c = 0; c < 3000 && idle_run < 5; c++) begin
      if (latch_done_in) latch_done_in = 1'b0;
      else if (latch_req_out) latch_done_in = 1'b1;
      tick(1);
      idle_run = busy_out ? 0 : idle_run + 1;
    end
    latch_done_in = 1'b0;
    check("rand drained to idle", idle_run, 5);
    check("rand scans ran", scan_cnt - s0 > 0, 1);
    check("rand words per scan", acc_cnt - a0, N * (scan_cnt - s0));
`ifndef AUTO_REFRESH_EN
    check("rand frames = scans + drops", rdy_pulses, (scan_cnt - s0) + (drop_cnt - d0));
`endif

`ifdef AUTO_REFRESH_EN
    // Test 6: idle auto-refresh rescans the front bank without a swap
    sb_en = 0;
    for (int r = 0; r < 2; r++) begin
      t0 = tog_cnt;
      n = 0;
      while (!busy_out && n < 200) begin
        tick(1);
        n++;
      end
      check($sformatf("t6 refresh%0d interval", r), (n >= 90 && n <= 110), 1);
      finish_scan($sformatf("t6 refresh%0d", r));
      check($sformatf("t6 refresh%0d no swap", r), tog_cnt - t0, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
